// File: rtl/io_requester.sv
// io_requester: single-word initiator for the IO bridge ReqW/AckW and ReqR/AckR four-phase handshakes
module io_requester #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  done_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  err_o,
  output logic                  ReqW_o,
  output logic                  ReqR_o,
  output logic [DATA_WIDTH-1:0] Data_o,
  input  logic                  AckW_i,
  input  logic                  AckR_i,
  input  logic [DATA_WIDTH-1:0] Data_i
);
  typedef enum logic [2:0] {IDLE, W_REQ, W_REL, R_REQ, R_REL, ABORT} state_t;
  state_t state, state_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic wait_st, met, expired, accept;
  assign accept = (state == IDLE) && cmd_valid_i;
  assign cmd_ready_o = (state == IDLE);
  assign ReqW_o = (state == W_REQ);
  assign ReqR_o = (state == R_REQ);
  // Awaited ack condition for the current handshake phase and its timeout
  always_comb begin
    wait_st = (state == W_REQ) || (state == W_REL) || (state == R_REQ) || (state == R_REL);
    met = (state == W_REQ) ? AckW_i :
          (state == W_REL) ? !AckW_i :
          (state == R_REQ) ? AckR_i :
          (state == R_REL) ? !AckR_i : 1'b0;
    expired = wait_st && !met && (cnt == CNT_WIDTH'(TIMEOUT - 1));
  end
  // Next-state selection; a met ack advances the handshake, an expired wait aborts
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = accept ? (cmd_wr_i ? W_REQ : R_REQ) : IDLE;
      W_REQ:   state_d = met ? W_REL : expired ? ABORT : W_REQ;
      W_REL:   state_d = met ? IDLE : expired ? ABORT : W_REL;
      R_REQ:   state_d = met ? R_REL : expired ? ABORT : R_REQ;
      R_REL:   state_d = met ? IDLE : expired ? ABORT : R_REL;
      ABORT:   state_d = (!AckW_i && !AckR_i) ? IDLE : ABORT;
      default: state_d = IDLE;
    endcase
  end
  // State, per-state wait counter, status pulses and data registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      cnt         <= '0;
      done_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      err_o       <= 1'b0;
      Data_o      <= '0;
      rsp_data_o  <= '0;
    end else begin
      state       <= state_d;
      cnt         <= (state_d != state || !wait_st) ? '0 : cnt + 1'b1;
      done_o      <= ((state == W_REL) || (state == R_REL)) && met;
      rsp_valid_o <= (state == R_REL) && met;
      err_o       <= expired;
      if (accept && cmd_wr_i) Data_o <= cmd_data_i;
      if ((state == R_REQ) && AckR_i) rsp_data_o <= Data_i;
    end
  end
endmodule
